fetch_queue: RTL and testbench
==============================

FETCH_QUEUE -- requirements
Module: fetch_queue

Interface
REQ-001 SHALL have parameter IMEM_POWER, default 18, meaning log2 of instruction-memory depth in words.
REQ-002 SHALL have parameter DEPTH, default 4, meaning prefetch queue entries; legal values are powers of two, 2..16.
REQ-003 SHALL have parameter RESET_PC, default 0, meaning the PC loaded at reset.
REQ-004 SHALL have port clk, input, 1 bit: the single clock, all state on the rising edge.
REQ-005 SHALL have port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 SHALL have port en, input, 1 bit: fetch enable; gates pushes and PC advance only.
REQ-007 SHALL have port PCSrcM, input, 1 bit: redirect request from memory stage.
REQ-008 SHALL have port pcM, input, `WORD bits: redirect target.
REQ-009 SHALL have port readyD, input, 1 bit: decode accepts the head entry this cycle.
REQ-010 SHALL have port pcD, output, `WORD bits: PC of the head entry.
REQ-011 SHALL have port instrD, output, `WORD bits: instruction of the head entry.
REQ-012 SHALL have port validD, output, 1 bit: the head entry is valid (queue not empty).
REQ-013 SHALL have port countQ, output, $clog2(DEPTH+1) bits: current occupancy.

Function
REQ-014 SHALL hold a PC register; the instruction read is combinational, RAM[pc >> 2], from a word array of 2^IMEM_POWER entries, with pc bits above the index ignored.
REQ-015 SHALL push {pc, instr} and advance pc by 4 when en=1, PCSrcM=0, and (countQ<DEPTH or a pop occurs this cycle).
REQ-016 SHALL pop the head when validD=1, readyD=1 and PCSrcM=0.
REQ-017 SHALL, when full and not popping, neither push nor advance pc.
REQ-018 SHALL, when en=0, hold pc and not push, while pops continue normally.
REQ-019 SHALL, on a simultaneous push and pop, leave countQ unchanged and keep FIFO order.
REQ-020 SHALL wrap the read and write pointers modulo DEPTH.
REQ-021 SHALL, when PCSrcM=1, take priority over all other events: the queue empties (countQ=0 next cycle), pc<=pcM, and no push or pop occurs that cycle.
REQ-022 SHALL present the first fetched instruction of a redirect one cycle after pc takes the target, i.e. validD is low for exactly one cycle after a redirect when en=1.
REQ-023 SHALL drive pcD and instrD from registered queue storage only; no combinational path from RAM or pcM to the outputs.
REQ-024 SHALL drive pcD and instrD to 0 when validD=0.

Reset
REQ-025 SHALL, while reset=0 at a clock edge, set pc=RESET_PC, pointers=0, countQ=0, validD=0, pcD=0 and instrD=0; RAM contents are not reset.
REQ-026 SHALL, on a reset asserted mid-operation, discard all queued entries in that cycle, with the reset taking priority over PCSrcM, push and pop.
REQ-027 SHALL produce the first push on the first edge with reset=1 and en=1, with validD=1 one cycle later.

Configuration
REQ-028 SHALL, with `FETCH_QUEUE_ALIGN_CHECK_EN defined, add output misalign (1 bit), set sticky when a redirect has pcM[1:0]!=0; while misalign=1 the block does not push, and only reset clears misalign.
REQ-029 SHALL, without `FETCH_QUEUE_ALIGN_CHECK_EN defined, have no misalign port, and SHALL truncate redirect targets to word alignment (pcM & ~3).

Structure
REQ-030 SHALL take `WORD and the entry typedef fq_entry_t {pc, instr} from the shared package fetch_pkg.
REQ-031 SHALL implement the storage, pointers and count as one sub-module, sync_fifo, parameterised on entry type and DEPTH, with flush, push and pop inputs.
REQ-032 SHALL keep the PC, memory, redirect and alignment logic in fetch_queue itself.

Verification
REQ-033 SHALL cover reset then streaming: RAM[0..7]=i+100, readyD=1, en=1 -> validD rises on the 2nd edge after reset release; pcD=0,4,8,... and instrD=100,101,... every cycle.
REQ-034 SHALL cover fill to full: DEPTH=4, readyD=0 for 6 cycles -> countQ saturates at 4, pc holds at 16; then readyD=1 -> entries 0,4,8,12 are delivered in order with no gap.
REQ-035 SHALL cover redirect while full: countQ=4, PCSrcM=1, pcM=0x40 -> next cycle countQ=0 and validD=0; one cycle later pcD=0x40 with instrD=RAM[16].
REQ-036 SHALL cover redirect coinciding with readyD=1 and en=1 -> no pop is counted, the old head is never delivered after the redirect, and the first delivered pcD is the target.
REQ-037 SHALL cover en low: en=0 for 3 cycles with readyD=1 -> the queue drains to countQ=0 and pc is unchanged; after en returns to 1 the sequence resumes at the held pc.
REQ-038 SHALL cover, with the macro defined, pcM=0x42 -> misalign=1, with no further pushes until reset; without the macro, the same stimulus -> pcD=0x40.

Source files
------------

// File: rtl/fetch_pkg.sv
// rtl/fetch_pkg.sv - shared word width and queue entry type for the fetch path
`ifndef WORD
`define WORD [31:0]
`endif

package fetch_pkg;

   localparam int WORD_W = 32;

   typedef struct packed {
      logic `WORD pc;
      logic `WORD instr;
   } fq_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - generic synchronous FIFO with flush, power-of-two depth
module sync_fifo #(
   parameter type T     = logic [63:0],
   parameter int  DEPTH = 4,
   localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
   localparam int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          resetn,
   input  logic          flush,
   input  logic          push,
   input  logic          pop,
   input  T              din,
   output T              head,
   output logic [CW-1:0] count,
   output logic          empty,
   output logic          full
);

   T              mem_q [DEPTH];
   logic [AW-1:0] wr_ptr_q, wr_ptr_d;
   logic [AW-1:0] rd_ptr_q, rd_ptr_d;
   logic [CW-1:0] count_q, count_d;

   assign head  = mem_q[rd_ptr_q];
   assign count = count_q;
   assign empty = (count_q == '0);
   assign full  = (count_q == CW'(DEPTH));

   // next pointers and occupancy; pointers wrap naturally because DEPTH is a power of two
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (push) wr_ptr_d = wr_ptr_q + AW'(1);
         if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
         case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
         endcase
      end
   end

   // pointer and count registers, cleared by reset
   always_ff @(posedge clk) begin
      if (!resetn) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // entry storage; contents need no reset since count gates visibility
   always_ff @(posedge clk) begin
      if (resetn && !flush && push) mem_q[wr_ptr_q] <= din;
   end

endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - PC, instruction ROM read and prefetch queue; option macro FETCH_QUEUE_ALIGN_CHECK_EN
module fetch_queue
   import fetch_pkg::*;
#(
   parameter int         IMEM_POWER = 18,
   parameter int         DEPTH      = 4,
   parameter logic [31:0] RESET_PC  = 32'h0
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       en,
   input  logic                       PCSrcM,
   input  logic `WORD                 pcM,
   input  logic                       readyD,
   output logic `WORD                 pcD,
   output logic `WORD                 instrD,
   output logic                       validD,
   output logic [$clog2(DEPTH+1)-1:0] countQ
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
   ,
   output logic                       misalign
`endif
);

   localparam int CW = $clog2(DEPTH + 1);

   logic `WORD imem [2**IMEM_POWER];

   logic `WORD pc_q, pc_d;
   logic `WORD instr_f;
   logic `WORD target;
   logic       push, pop, full, empty, hold_push;
   fq_entry_t  din, head;
   logic [CW-1:0] count;

   assign instr_f = imem[pc_q[IMEM_POWER+1:2]];

`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
   logic misalign_q, misalign_d;

   assign target    = pcM;
   assign hold_push = misalign_q;
   assign misalign  = misalign_q;

   // a misaligned redirect latches the flag until reset
   always_comb begin
      misalign_d = misalign_q;
      if (PCSrcM && (pcM[1:0] != 2'b00)) misalign_d = 1'b1;
   end

   // sticky misalign register
   always_ff @(posedge clk) begin
      if (!reset) misalign_q <= 1'b0;
      else        misalign_q <= misalign_d;
   end
`else
   assign target    = pcM & ~32'h3;
   assign hold_push = 1'b0;
`endif

   // a redirect suppresses both queue operations in its cycle
   assign pop  = !empty && readyD && !PCSrcM;
   assign push = en && !PCSrcM && !hold_push && (!full || pop);

   assign din.pc    = pc_q;
   assign din.instr = instr_f;

   // redirect wins; otherwise pc moves only with a push
   always_comb begin
      pc_d = pc_q;
      if (PCSrcM)    pc_d = target;
      else if (push) pc_d = pc_q + 32'd4;
   end

   // program counter register
   always_ff @(posedge clk) begin
      if (!reset) pc_q <= RESET_PC;
      else        pc_q <= pc_d;
   end

   sync_fifo #(
      .T     (fq_entry_t),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk    (clk),
      .resetn (reset),
      .flush  (PCSrcM),
      .push   (push),
      .pop    (pop),
      .din    (din),
      .head   (head),
      .count  (count),
      .empty  (empty),
      .full   (full)
   );

   assign validD = !empty;
   assign countQ = count;
   assign pcD    = validD ? head.pc    : '0;
   assign instrD = validD ? head.instr : '0;

endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - randomized and directed check of fetch_queue against a queue model
module tb_fetch_queue;

   localparam int IMEM_POWER = 8;
   localparam int DEPTH      = 4;
   localparam int NWORDS     = 2**IMEM_POWER;

   logic        clk;
   logic        reset;
   logic        en;
   logic        PCSrcM;
   logic [31:0] pcM;
   logic        readyD;
   logic [31:0] pcD;
   logic [31:0] instrD;
   logic        validD;
   logic [2:0]  countQ;
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
   logic        misalign;
`endif

   fetch_queue #(
      .IMEM_POWER (IMEM_POWER),
      .DEPTH      (DEPTH),
      .RESET_PC   (32'h0)
   ) dut (
      .clk    (clk),
      .reset  (reset),
      .en     (en),
      .PCSrcM (PCSrcM),
      .pcM    (pcM),
      .readyD (readyD),
      .pcD    (pcD),
      .instrD (instrD),
      .validD (validD),
      .countQ (countQ)
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
      ,
      .misalign (misalign)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ment_t;

   logic [31:0] mem [NWORDS];
   ment_t       q[$];
   logic [31:0] mpc;
   logic        mmis;

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   // model: what one clock edge does to the queue, given the applied inputs
   task automatic model_edge();
      if (!reset) begin
         q.delete();
         mpc  = 32'h0;
         mmis = 1'b0;
      end else if (PCSrcM) begin
         q.delete();
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
         mpc = pcM;
         if (pcM[1:0] != 2'b00) mmis = 1'b1;
`else
         mpc = {pcM[31:2], 2'b00};
`endif
      end else begin
         bit do_pop, do_push;
         ment_t e;
         do_pop  = (q.size() > 0) && readyD;
         do_push = en && !mmis && ((q.size() < DEPTH) || do_pop);
         if (do_pop) void'(q.pop_front());
         if (do_push) begin
            e.pc    = mpc;
            e.instr = mem[(mpc >> 2) % NWORDS];
            q.push_back(e);
            mpc = mpc + 32'd4;
         end
      end
   endtask

   // compare every DUT output against the model state
   task automatic check_model();
      chk("validD", {31'b0, validD}, {31'b0, q.size() > 0});
      chk("countQ", {29'b0, countQ}, q.size());
      chk("pcD",    pcD,    (q.size() > 0) ? q[0].pc    : 32'h0);
      chk("instrD", instrD, (q.size() > 0) ? q[0].instr : 32'h0);
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
      chk("misalign", {31'b0, misalign}, {31'b0, mmis});
`endif
   endtask

   // apply inputs at the falling edge, advance the model at the rising edge, check at the next falling edge
   task automatic step(input logic r, input logic e, input logic ps, input logic [31:0] pm, input logic rd);
      reset  = r;
      en     = e;
      PCSrcM = ps;
      pcM    = pm;
      readyD = rd;
      @(posedge clk);
      model_edge();
      @(negedge clk);
      check_model();
   endtask

   task automatic do_reset();
      step(1'b0, 1'b1, 1'b0, 32'h0, 1'b0);
   endtask

   initial begin
      reset = 1'b0; en = 1'b0; PCSrcM = 1'b0; pcM = 32'h0; readyD = 1'b0;
      q.delete();
      mpc  = 32'h0;
      mmis = 1'b0;
      for (int i = 0; i < NWORDS; i++) begin
         mem[i] = (i < 8) ? 32'(i + 100) : $urandom;
      end
      mem[16] = 32'hCAFE_0010;
      for (int i = 0; i < NWORDS; i++) dut.imem[i] = mem[i];

      @(negedge clk);

      // reset state
      do_reset();
      do_reset();
      chk("rst_valid", {31'b0, validD}, 32'h0);
      chk("rst_count", {29'b0, countQ}, 32'h0);
      chk("rst_pcD",   pcD,    32'h0);
      chk("rst_instr", instrD, 32'h0);

      // streaming from reset with decode always ready
      for (int k = 1; k <= 8; k++) begin
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
         chk("stream_valid", {31'b0, validD}, 32'h1);
         chk("stream_pc",    pcD,    32'(4 * (k - 1)));
         chk("stream_instr", instrD, 32'(100 + k - 1));
      end

      // fill to full, then drain in order
      do_reset();
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("full_count", {29'b0, countQ}, 32'd4);
      for (int j = 0; j <= 4; j++) begin
         chk("drain_pc", pcD, 32'(4 * j));
         step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      end

      // redirect while full
      do_reset();
      for (int k = 0; k < 6; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      step(1'b1, 1'b1, 1'b1, 32'h40, 1'b0);
      chk("redir_count", {29'b0, countQ}, 32'h0);
      chk("redir_valid", {31'b0, validD}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      chk("redir_pc",    pcD,    32'h40);
      chk("redir_instr", instrD, 32'hCAFE_0010);

      // redirect coinciding with a ready decode
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h80, 1'b1);
      chk("rdy_redir_valid", {31'b0, validD}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("rdy_redir_pc", pcD, 32'h80);

      // fetch disabled: queue drains, pc held
      do_reset();
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b0, 1'b0, 32'h0, 1'b1);
      chk("en_low_count", {29'b0, countQ}, 32'h0);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("en_resume_pc", pcD, 32'd12);

      // misaligned redirect target
      do_reset();
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      step(1'b1, 1'b1, 1'b1, 32'h42, 1'b1);
      step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
`ifdef FETCH_QUEUE_ALIGN_CHECK_EN
      chk("mis_flag",  {31'b0, misalign}, 32'h1);
      chk("mis_valid", {31'b0, validD},   32'h0);
      for (int k = 0; k < 3; k++) step(1'b1, 1'b1, 1'b0, 32'h0, 1'b1);
      chk("mis_hold", {29'b0, countQ}, 32'h0);
`else
      chk("trunc_pc",    pcD,    32'h40);
      chk("trunc_instr", instrD, 32'hCAFE_0010);
`endif

      // randomized traffic against the model
      do_reset();
      for (int n = 0; n < 3000; n++) begin
         logic        r, e, ps, rd;
         logic [31:0] pm;
         r  = ($urandom_range(0, 99) != 0);
         e  = ($urandom_range(0, 3) != 0);
         ps = ($urandom_range(0, 15) == 0);
         rd = ($urandom_range(0, 2) != 0);
         case ($urandom_range(0, 7))
            0:       pm = $urandom;
            1:       pm = $urandom & 32'h3FF;
            default: pm = $urandom & 32'h3FC;
         endcase
         step(r, e, ps, pm, rd);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
